// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
// div_sequencer
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. It computes one
// quotient bit per cycle and holds the pipeline frozen through stall_o while
// it works. Divide-by-zero and signed overflow finish in a single cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start_i   EX stage holds a valid divide instruction
//   op_i      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_i     dividend
//   rs2_i     divisor
//   abort_i   kill any in-flight operation
//   stall_o   pipeline freeze request (combinational)
//   busy_o    FSM is not IDLE
//   done_o    one-cycle pulse, result_o valid
//   result_o  quotient or remainder, held until the next completion
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            abort_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t          state;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;
  logic [4:0]      cnt;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  // Operand preparation for the start cycle: op_i[0]=0 marks the signed
  // forms, and the magnitudes are taken here so the iteration is unsigned.
  // The most negative value maps onto itself, which is already its correct
  // unsigned magnitude.
  logic            op_signed;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;
  logic            div_by_zero;
  logic            overflow;

  always_comb begin
    op_signed   = ~op_i[0];
    rs1_abs     = (op_signed && rs1_i[XLEN-1]) ? (~rs1_i + 1'b1) : rs1_i;
    rs2_abs     = (op_signed && rs2_i[XLEN-1]) ? (~rs2_i + 1'b1) : rs2_i;
    div_by_zero = (rs2_i == '0);
    overflow    = op_signed && (rs1_i == MOST_NEG) && (rs2_i == ALL_ONES);
  end

  // One restoring step: bring down the next dividend bit into a 33-bit
  // partial remainder and subtract the divisor if it fits. Because the
  // remainder is always below the divisor, the result fits back into XLEN bits.
  logic [XLEN:0]   r_shift;
  logic            r_ge;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    r_shift = {rem, dvd[XLEN-1]};
    r_ge    = (r_shift >= {1'b0, dvs});
    quo_fix = neg_q ? (~quo + 1'b1) : quo;
    rem_fix = neg_r ? (~rem + 1'b1) : rem;
  end

  // Main sequencer. abort_i wins over everything and returns to IDLE without
  // touching result_o; special cases jump straight to DONE with their answer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      result_o <= '0;
    end else if (abort_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            is_rem <= op_i[1];
            if (div_by_zero) begin
              result_o <= op_i[1] ? rs1_i : ALL_ONES;
              state    <= DONE;
            end else if (overflow) begin
              result_o <= op_i[1] ? '0 : MOST_NEG;
              state    <= DONE;
            end else begin
              neg_q <= op_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
              neg_r <= op_signed && rs1_i[XLEN-1];
              dvd   <= rs1_abs;
              dvs   <= rs2_abs;
              quo   <= '0;
              rem   <= '0;
              cnt   <= 5'd31;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (r_ge) begin
            rem <= XLEN'(r_shift - {1'b0, dvs});
          end else begin
            rem <= r_shift[XLEN-1:0];
          end
          quo <= {quo[XLEN-2:0], r_ge};
          dvd <= {dvd[XLEN-2:0], 1'b0};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_o <= is_rem ? rem_fix : quo_fix;
          state    <= DONE;
        end
        DONE: begin
          // start_i here belongs to the instruction now leaving EX.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decoded from the registered state. The stall drops in the
  // DONE cycle so the pipeline can capture result_o, and is suppressed by
  // reset or abort so nothing stays frozen on a killed instruction.
  always_comb begin
    busy_o  = (state != IDLE);
    done_o  = (state == DONE);
    stall_o = !rst && !abort_i &&
              (((state == IDLE) && start_i) || (state == CALC) || (state == FIX));
  end

endmodule

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
// tb_div_sequencer
// Self-checking bench for div_sequencer: a table of directed divide vectors
// with hand-computed results and latencies, plus hand-written sequences for
// abort, asynchronous reset mid-operation and back-to-back issue.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        abort_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    int          exp_done;
    int          exp_stall;
  } vec_t;

  div_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .abort_i  (abort_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  // 10 ns clock; an absolute cycle counter lets sequences measure spacing.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: every check goes through here and bumps the counts.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one divide at a negedge (cycle 0), then watch each cycle at the
  // negedge, counting stall cycles and recording the cycle of done_o. The
  // operand buses are scrambled after cycle 0 to show they are not resampled.
  // Returns in the IDLE cycle right after DONE (just past its rising edge).
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, output int start_cyc,
                               output int done_cyc, output int stall_cnt,
                               output logic [31:0] res);
    @(negedge clk);
    op_i      = op;
    rs1_i     = a;
    rs2_i     = b;
    start_i   = 1'b1;
    start_cyc = cyc;
    done_cyc  = -1;
    stall_cnt = 0;
    res       = 32'h0;
    #1;
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (stall_o) stall_cnt++;
      if (done_o) begin
        done_cyc = c;
        res      = result_o;
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
      rs1_i   = $urandom;
      rs2_i   = $urandom;
    end
  endtask

  vec_t        vecs[$];
  int          s_cyc, d_cyc, st_cnt, s_cyc2, d_cyc2, st_cnt2;
  logic [31:0] res, res2, prev;
  int          seen_done;

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    rs1_i   = 32'h0;
    rs2_i   = 32'h0;
    abort_i = 1'b0;

    vecs.push_back('{"divu_100_7",      OP_DIVU, 32'd100,       32'd7,         32'd14,        34, 34});
    vecs.push_back('{"remu_100_7",      OP_REMU, 32'd100,       32'd7,         32'd2,         34, 34});
    vecs.push_back('{"div_m7_2",        OP_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  34, 34});
    vecs.push_back('{"rem_m7_2",        OP_REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  34, 34});
    vecs.push_back('{"div_7_m2",        OP_DIV,  32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  34, 34});
    vecs.push_back('{"rem_7_m2",        OP_REM,  32'd7,         32'hFFFFFFFE,  32'd1,         34, 34});
    vecs.push_back('{"div_m7_m2",       OP_DIV,  32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         34, 34});
    vecs.push_back('{"rem_m7_m2",       OP_REM,  32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF,  34, 34});
    vecs.push_back('{"divu_5_0",        OP_DIVU, 32'd5,         32'd0,         32'hFFFFFFFF,  1,  1});
    vecs.push_back('{"remu_5_0",        OP_REMU, 32'd5,         32'd0,         32'd5,         1,  1});
    vecs.push_back('{"div_m5_0",        OP_DIV,  32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  1,  1});
    vecs.push_back('{"rem_m5_0",        OP_REM,  32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1,  1});
    vecs.push_back('{"div_ovf",         OP_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  1});
    vecs.push_back('{"rem_ovf",         OP_REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,         1,  1});
    vecs.push_back('{"divu_ovf_ops",    OP_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         34, 34});
    vecs.push_back('{"div_mostneg_2",   OP_DIV,  32'h80000000,  32'd2,         32'hC0000000,  34, 34});
    vecs.push_back('{"divu_max_16",     OP_DIVU, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  34, 34});
    vecs.push_back('{"remu_max_16",     OP_REMU, 32'hFFFFFFFF,  32'h10,        32'h0000000F,  34, 34});

    // Reset state
    #12;
    checkOutput("reset_busy",   {31'b0, busy_o},  32'd0);
    checkOutput("reset_done",   {31'b0, done_o},  32'd0);
    checkOutput("reset_stall",  {31'b0, stall_o}, 32'd0);
    checkOutput("reset_result", result_o,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, s_cyc, d_cyc, st_cnt, res);
      checkOutput({vecs[i].name, "_result"}, res, vecs[i].exp_result);
      checkOutput({vecs[i].name, "_done_cycle"}, d_cyc, vecs[i].exp_done);
      checkOutput({vecs[i].name, "_stall_cycles"}, st_cnt, vecs[i].exp_stall);
      checkOutput({vecs[i].name, "_done_single"}, {31'b0, done_o}, 32'd0);
    end

    // Abort in cycle 10 of a DIVU: no done, result unchanged, then a fresh DIVU
    prev = result_o;
    @(negedge clk);
    op_i    = OP_DIVU;
    rs1_i   = 32'h1234;
    rs2_i   = 32'd5;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    abort_i = 1'b1;
    #1;
    checkOutput("abort_stall_low", {31'b0, stall_o}, 32'd0);
    checkOutput("abort_busy_before", {31'b0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    checkOutput("abort_idle_next", {31'b0, busy_o}, 32'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen_done++;
    end
    checkOutput("abort_no_done", seen_done, 32'd0);
    checkOutput("abort_result_kept", result_o, prev);
    applyStimulus(OP_DIVU, 32'd9, 32'd3, s_cyc, d_cyc, st_cnt, res);
    checkOutput("after_abort_result", res, 32'd3);
    checkOutput("after_abort_done_cycle", d_cyc, 32'd34);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    op_i    = OP_DIVU;
    rs1_i   = 32'd5000;
    rs2_i   = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("midcalc_busy", {31'b0, busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy",   {31'b0, busy_o},  32'd0);
    checkOutput("async_rst_stall",  {31'b0, stall_o}, 32'd0);
    checkOutput("async_rst_result", result_o,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back DIVU: second start in the IDLE cycle right after DONE
    applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'd1, s_cyc, d_cyc, st_cnt, res);
    applyStimulus(OP_DIVU, 32'd1000, 32'd10, s_cyc2, d_cyc2, st_cnt2, res2);
    checkOutput("b2b_first_result", res, 32'hFFFFFFFF);
    checkOutput("b2b_first_done", d_cyc, 32'd34);
    checkOutput("b2b_second_result", res2, 32'd100);
    checkOutput("b2b_second_done_abs", (s_cyc2 + d_cyc2) - s_cyc, 32'd69);
    checkOutput("b2b_second_stall", st_cnt2, 32'd34);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
